dds_io_port: RTL and testbench

I/O-mapped peripheral on the J1 core's `io_*` bus that drives the AD9958 DDS serial port and supplies the CPU's timer interrupt. It decodes one-hot `io_addr` bits, serialises 8- or 16-bit words MSB-first on SCLK/SDIO, and gives firmware manual chip select and a deferred IO_UPDATE strobe. It also runs a reloadable 16-bit down-counter whose expiry drives `interrupt_request` back into the core.

---
 rtl/dds_io_port_if.sv | 25 ++
 rtl/dds_io_port.sv | 238 +++++++++++++++++++++++
 tb/tb_dds_io_port.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_io_port_if.sv
// J1 io_* bus bundle between the CPU and dds_io_port.
// One-hot io_addr, single-cycle strobes, registered read data.
interface dds_io_port_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (
        output io_rd,
        output io_wr,
        output io_addr,
        output io_dout,
        input  io_din
    );

    modport slave (
        input  io_rd,
        input  io_wr,
        input  io_addr,
        input  io_dout,
        output io_din
    );
endinterface

// File: rtl/dds_io_port.sv
// AD9958 serial port driver and reloadable timer on the J1 io_* bus.
// SPI shifter, chip select, deferred IO_UPDATE pulse, timer interrupt.
module dds_io_port #(
    parameter int CLKDIV = 2,
    parameter int UPDLEN = 4
) (
    input  logic         clk,
    input  logic         resetq,
    dds_io_port_if.slave bus,
    output logic         interrupt_request,
    output logic         dds_sclk,
    output logic         dds_sdio,
    output logic         dds_cs_n,
    output logic         dds_ioupdate
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } spi_state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [3:0] UPD_LAST = 4'(UPDLEN - 1);

    logic sel_spi8;
    logic sel_spi16;
    logic sel_ctl;
    logic sel_tmr;
    logic sel_ack;

    assign sel_spi8  = bus.io_addr[8];
    assign sel_spi16 = bus.io_addr[9];
    assign sel_ctl   = bus.io_addr[10];
    assign sel_tmr   = bus.io_addr[11];
    assign sel_ack   = bus.io_addr[12];

    logic unused_addr;
    assign unused_addr = ^{bus.io_addr[15:13], bus.io_addr[7:0]};

    logic wr_data;
    logic wr_wide;
    logic wr_ctl;
    logic wr_tmr;
    logic wr_ack;
    logic rd_stat;
    logic upd_req;

    assign wr_data = bus.io_wr & (sel_spi8 | sel_spi16);
    assign wr_wide = bus.io_wr & sel_spi16;
    assign wr_ctl  = bus.io_wr & sel_ctl;
    assign wr_tmr  = bus.io_wr & sel_tmr;
    assign wr_ack  = bus.io_wr & sel_ack;
    assign rd_stat = bus.io_rd & sel_spi8;
    assign upd_req = wr_ctl & bus.io_dout[1];

    spi_state_t  state;
    logic [15:0] shreg;
    logic [4:0]  nbits;
    logic [7:0]  div_cnt;
    logic        busy;
    logic        overrun;

    assign busy = (state != S_IDLE);

    // Each bit: CLKDIV cycles low, then CLKDIV cycles high.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state    <= S_IDLE;
            shreg    <= '0;
            nbits    <= '0;
            div_cnt  <= '0;
            dds_sclk <= 1'b0;
            dds_sdio <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (wr_data) begin
                        state    <= S_LOW;
                        div_cnt  <= '0;
                        dds_sclk <= 1'b0;
                        if (wr_wide) begin
                            shreg    <= bus.io_dout;
                            nbits    <= 5'd16;
                            dds_sdio <= bus.io_dout[15];
                        end else begin
                            shreg    <= {bus.io_dout[7:0], 8'h00};
                            nbits    <= 5'd8;
                            dds_sdio <= bus.io_dout[7];
                        end
                    end
                end
                S_LOW: begin
                    if (div_cnt == DIV_LAST) begin
                        state    <= S_HIGH;
                        div_cnt  <= '0;
                        dds_sclk <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        dds_sclk <= 1'b0;
                        shreg    <= {shreg[14:0], 1'b0};
                        nbits    <= nbits - 5'd1;
                        if (nbits == 5'd1) begin
                            state    <= S_IDLE;
                            dds_sdio <= 1'b0;
                        end else begin
                            state    <= S_LOW;
                            dds_sdio <= shreg[14];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    dds_sclk <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overrun <= 1'b0;
        end else if (wr_data && busy) begin
            overrun <= 1'b1;
        end else if (rd_stat) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            dds_cs_n <= 1'b1;
        end else if (wr_ctl) begin
            dds_cs_n <= bus.io_dout[0];
        end
    end

    logic       upd_pend;
    logic [3:0] upd_cnt;

    // A request landing while a pulse runs or one is queued is absorbed.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            upd_pend     <= 1'b0;
            upd_cnt      <= '0;
            dds_ioupdate <= 1'b0;
        end else if (dds_ioupdate) begin
            if (upd_cnt == 4'd0) begin
                dds_ioupdate <= 1'b0;
            end else begin
                upd_cnt <= upd_cnt - 4'd1;
            end
        end else if (upd_pend) begin
            if (!busy) begin
                upd_pend     <= 1'b0;
                dds_ioupdate <= 1'b1;
                upd_cnt      <= UPD_LAST;
            end
        end else if (upd_req) begin
            if (busy) begin
                upd_pend <= 1'b1;
            end else begin
                dds_ioupdate <= 1'b1;
                upd_cnt      <= UPD_LAST;
            end
        end
    end

    logic [15:0] reload;
    logic [15:0] tmr_cnt;
    logic        expire;

    assign expire = !wr_tmr && (reload != '0) && (tmr_cnt == '0);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            reload  <= '0;
            tmr_cnt <= '0;
        end else if (wr_tmr) begin
            reload  <= bus.io_dout;
            tmr_cnt <= bus.io_dout;
        end else if (reload != '0) begin
            if (tmr_cnt == '0) begin
                tmr_cnt <= reload;
            end else begin
                tmr_cnt <= tmr_cnt - 16'd1;
            end
        end
    end

    // Expiry beats a same-cycle acknowledge so no tick is lost.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            interrupt_request <= 1'b0;
        end else if (expire) begin
            interrupt_request <= 1'b1;
        end else if (wr_ack) begin
            interrupt_request <= 1'b0;
        end
    end

    logic [15:0] rdata;
    logic [15:0] din_q;

    always_comb begin
        rdata = '0;
        if (sel_spi8) begin
            rdata = rdata | {14'b0, overrun, busy};
        end
        if (sel_ctl) begin
            rdata = rdata | {14'b0, upd_pend | dds_ioupdate, dds_cs_n};
        end
        if (sel_tmr) begin
            rdata = rdata | tmr_cnt;
        end
        if (sel_ack) begin
            rdata = rdata | {15'b0, interrupt_request};
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            din_q <= '0;
        end else if (bus.io_rd) begin
            din_q <= rdata;
        end
    end

    assign bus.io_din = din_q;

endmodule

// File: tb/tb_dds_io_port.sv
// Directed and randomized checks of dds_io_port against a behavioural model.
// Pin activity is captured on falling clock edges.
module tb_dds_io_port;

    localparam int CLKDIV = 2;
    localparam int UPDLEN = 4;

    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic irq;
    logic sclk;
    logic sdio;
    logic cs_n;
    logic ioupd;

    dds_io_port_if bus ();

    dds_io_port #(
        .CLKDIV(CLKDIV),
        .UPDLEN(UPDLEN)
    ) dut (
        .clk              (clk),
        .resetq           (resetq),
        .bus              (bus),
        .interrupt_request(irq),
        .dds_sclk         (sclk),
        .dds_sdio         (sdio),
        .dds_cs_n         (cs_n),
        .dds_ioupdate     (ioupd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int   cyc = 0;
    logic sclk_prev = 1'b0;
    logic bitq[$];
    int   edgeq[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sclk && !sclk_prev) begin
            bitq.push_back(sdio);
            edgeq.push_back(cyc);
        end
        sclk_prev = sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_addr = a;
        bus.io_dout = d;
        bus.io_wr = 1'b1;
        step();
        bus.io_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        bus.io_addr = a;
        bus.io_rd = 1'b1;
        step();
        bus.io_rd = 1'b0;
        v = bus.io_din;
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] v;
        int n;
        n = 0;
        do begin
            rd(16'h0100, v);
            n++;
        end while (v[0] && n < 300);
        chk(tag, {31'b0, v[0]}, 0);
    endtask

    function automatic logic [15:0] spi_word(input bit wide,
                                             input logic [15:0] d);
        return wide ? d : {8'h00, d[7:0]};
    endfunction

    function automatic logic [15:0] got_word();
        logic [15:0] w;
        w = '0;
        foreach (bitq[i]) w = {w[14:0], bitq[i]};
        return w;
    endfunction

    function automatic int bad_gaps();
        int b;
        b = 0;
        for (int i = 1; i < edgeq.size(); i++)
            if (edgeq[i] - edgeq[i-1] != 2 * CLKDIV) b++;
        return b;
    endfunction

    // Counter value j edges after loading reload value r.
    function automatic int tmr_val(input int r, input int j);
        return r - (j % (r + 1));
    endfunction

    initial begin
        logic [15:0] v;
        logic [15:0] a;
        int ones;
        int rise;
        int highs;
        int pulses;
        int exp_rise;
        int r;
        int k;
        int d;
        int n;
        bit wide;
        bit prev;
        bit pend;

        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        bus.io_addr = '0;
        bus.io_dout = '0;
        resetq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din", bus.io_din, 0);
        chk("rst_irq", irq, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdio", sdio, 0);
        chk("rst_cs", cs_n, 1);
        chk("rst_upd", ioupd, 0);
        resetq = 1'b1;
        step();
        rd(16'h0800, v);
        chk("rst_cnt", v, 0);
        rd(16'h0100, v);
        chk("rst_stat", v, 0);
        rd(16'h0400, v);
        chk("rst_ctl", v, 1);

        // 8-bit 0xA5 with status polled every cycle
        bitq.delete();
        edgeq.delete();
        bus.io_addr = 16'h0100;
        bus.io_dout = 16'h00A5;
        bus.io_wr = 1'b1;
        bus.io_rd = 1'b1;
        step();
        bus.io_wr = 1'b0;
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.io_din[0]) ones++;
        end
        bus.io_rd = 1'b0;
        chk("a5_busy_len", ones, 2 * 8 * CLKDIV);
        chk("a5_nbits", bitq.size(), 8);
        chk("a5_bits", got_word(), 16'h00A5);
        chk("a5_gaps", bad_gaps(), 0);
        chk("a5_sclk_end", sclk, 0);

        for (int t = 0; t < 6; t++) begin
            wide = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 65535));
            a = wide ? ($urandom_range(0, 1) ? 16'h0300 : 16'h0200) : 16'h0100;
            a = a | 16'($urandom_range(0, 255));
            bitq.delete();
            edgeq.delete();
            wr(a, d[15:0]);
            wait_idle("rnd_idle");
            chk($sformatf("rnd%0d_nbits", t), bitq.size(), wide ? 16 : 8);
            chk($sformatf("rnd%0d_bits", t), got_word(), spi_word(wide, d[15:0]));
            chk($sformatf("rnd%0d_gaps", t), bad_gaps(), 0);
        end

        bitq.delete();
        edgeq.delete();
        wr(16'h0200, 16'h8001);
        repeat (5) step();
        wr(16'h0100, 16'h00FF);
        rd(16'h0100, v);
        chk("ovr_stat1", v, 3);
        rd(16'h0100, v);
        chk("ovr_stat2", v, 1);
        wait_idle("ovr_idle");
        chk("ovr_nbits", bitq.size(), 16);
        chk("ovr_bits", got_word(), 16'h8001);

        // Deferred IO_UPDATE behind an 8-bit transfer
        d = int'($urandom_range(0, 255));
        wr(16'h0100, d[15:0]);
        wr(16'h0400, 16'h0002);
        rd(16'h0400, v);
        chk("upd_pend", v, 2);
        exp_rise = 2 * 8 * CLKDIV + 1;
        rise = -1;
        highs = 0;
        pulses = 0;
        prev = 1'b0;
        for (int kk = 3; kk <= exp_rise + 20; kk++) begin
            if (kk == exp_rise + 2) begin
                bus.io_addr = 16'h0400;
                bus.io_dout = 16'h0002;
                bus.io_wr = 1'b1;
            end
            step();
            bus.io_wr = 1'b0;
            if (ioupd) begin
                highs++;
                if (!prev) begin
                    pulses++;
                    if (rise < 0) rise = kk;
                end
            end
            prev = ioupd;
        end
        chk("upd_rise", rise, exp_rise);
        chk("upd_width", highs, UPDLEN);
        chk("upd_pulses", pulses, 1);
        rd(16'h0400, v);
        chk("upd_done_ctl", v, 0);

        wr(16'h0400, 16'h0003);
        chk("upd_now", ioupd, 1);
        chk("cs_hi", cs_n, 1);
        highs = 1;
        repeat (10) begin
            step();
            if (ioupd) highs++;
        end
        chk("upd_now_width", highs, UPDLEN);

        wr(16'h0400, 16'h0000);
        chk("cs_lo", cs_n, 0);

        // Timer R=9: expiries 10, 20, 30 edges after the load
        wr(16'h0800, 16'd9);
        rise = -1;
        for (int kk = 1; kk <= 15; kk++) begin
            step();
            if (irq && rise < 0) rise = kk;
        end
        chk("tmr_first", rise, 10);
        wr(16'h1000, 16'h1234);
        chk("tmr_ack", irq, 0);
        repeat (3) step();
        chk("tmr_pre2", irq, 0);
        step();
        chk("tmr_second", irq, 1);
        repeat (9) step();
        wr(16'h1000, 16'h0000);
        chk("tmr_ack_vs_exp", irq, 1);
        wr(16'h1000, 16'h0000);
        chk("tmr_ack2", irq, 0);

        for (int t = 0; t < 3; t++) begin
            r = int'($urandom_range(3, 40));
            wr(16'h0800, r[15:0]);
            wr(16'h1000, 16'h0000);
            k = int'($urandom_range(2, 3 * (r + 1)));
            repeat (k - 2) step();
            rd(16'h1800, v);
            pend = (k - 1) >= (r + 1);
            chk($sformatf("tmr_rd%0d", t), v, tmr_val(r, k - 1) | int'(pend));
        end

        wr(16'h0800, 16'h0000);
        wr(16'h1000, 16'h0000);
        n = 0;
        repeat (50) begin
            step();
            if (irq) n++;
        end
        chk("tmr_off_irq", n, 0);
        rd(16'h0800, v);
        chk("tmr_off_cnt", v, 0);

        // Reset in the middle of a transfer
        wr(16'h0800, 16'd4);
        wr(16'h0400, 16'h0000);
        d = int'($urandom_range(0, 65535));
        wr(16'h0200, d[15:0]);
        repeat (6) step();
        chk("pre_rst_irq", irq, 1);
        n = 0;
        while (!sclk && n < 20) begin
            step();
            n++;
        end
        chk("pre_rst_sclk", sclk, 1);
        resetq = 1'b0;
        #1;
        chk("mid_rst_cs", cs_n, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_upd", ioupd, 0);
        step();
        resetq = 1'b1;
        rd(16'h0100, v);
        chk("post_rst_stat", v, 0);
        rd(16'h0800, v);
        chk("post_rst_cnt", v, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
